audio_nios_led_fader: RTL and testbench



---
 rtl/audio_nios_led_pkg.sv | 11 +
 rtl/audio_nios_led_channel.sv | 58 +++++
 rtl/audio_nios_led_fader.sv | 94 +++++++++
 tb/tb_audio_nios_led_fader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/audio_nios_led_pkg.sv
// Shared constants and types for the Nios LED fader: intensity level width,
// full-scale level and the top count of the PWM compare counter.
package audio_nios_led_pkg;

  localparam int LVL_BITS = 4;
  localparam int LVL_MAX  = (1 << LVL_BITS) - 1;
  localparam int PWM_TOP  = LVL_MAX - 1;

  typedef logic [LVL_BITS-1:0] level_t;

endpackage

// File: rtl/audio_nios_led_channel.sv
// One LED: peak-hold level register with stepped decay, and the PWM compare
// that turns the level into a duty cycle.
module audio_nios_led_channel
  import audio_nios_led_pkg::*;
(
  input  logic   clk_i,
  input  logic   reset_i,
  input  logic   enable_i,
  input  logic   freeze_i,
  input  logic   decay_tick_i,
  input  logic   pat_bit_i,
  input  level_t pwm_cnt_i,
  output logic   led_o,
  output logic   fade_o
);

  localparam level_t LVL_FULL = level_t'(LVL_MAX);
  localparam level_t LVL_ZERO = level_t'(0);
  localparam level_t LVL_ONE  = level_t'(1);

  level_t level_q, level_d;
  logic   led_q, led_d;

  // Level update priority and output compare.
  always_comb begin
    level_d = level_q;
    led_d   = 1'b0;
    if (!enable_i) begin
      level_d = pat_bit_i ? LVL_FULL : LVL_ZERO;
      // Bypass drives from the freshly loaded level so latency matches fade mode.
      led_d   = (level_q == LVL_FULL);
    end else begin
      if (pat_bit_i) begin
        level_d = LVL_FULL;
      end else if (decay_tick_i && !freeze_i && (level_q != LVL_ZERO)) begin
        level_d = level_q - LVL_ONE;
      end else begin
        level_d = level_q;
      end
      led_d = (level_q > pwm_cnt_i);
    end
  end

  // Level and LED registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= LVL_ZERO;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o  = led_q;
  assign fade_o = !pat_bit_i && (level_q != LVL_ZERO) && (level_q != LVL_FULL);

endmodule

// File: rtl/audio_nios_led_fader.sv
// VU-style LED fader behind the Nios LED PIO: pattern register, PWM and decay
// prescalers shared by all channels, and the registered fading flag.
module audio_nios_led_fader
  import audio_nios_led_pkg::*;
#(
  parameter int WIDTH     = 26,
  parameter int PWM_DIV   = 64,
  parameter int DECAY_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             freeze,
  input  logic [WIDTH-1:0] pattern_in,
  output logic [WIDTH-1:0] led_out,
  output logic             fading
);

  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(PWM_DIV - 1);
  localparam logic [DEC_W-1:0] DEC_TOP = DEC_W'(DECAY_DIV - 1);
  localparam level_t           CNT_TOP = level_t'(PWM_TOP);

  logic [WIDTH-1:0] pat_q;
  logic [PRE_W-1:0] pwm_pre_q, pwm_pre_d;
  level_t           pwm_cnt_q, pwm_cnt_d;
  logic [DEC_W-1:0] decay_pre_q, decay_pre_d;
  logic             fading_q, fading_d;
  logic             pwm_tick, period_end, decay_tick;
  logic [WIDTH-1:0] fade_vec;

  // Prescaler next-state; bypass parks every timer at zero.
  always_comb begin
    pwm_tick    = (pwm_pre_q == PRE_TOP);
    period_end  = pwm_tick && (pwm_cnt_q == CNT_TOP);
    decay_tick  = enable && period_end && (decay_pre_q == DEC_TOP);
    pwm_pre_d   = pwm_pre_q;
    pwm_cnt_d   = pwm_cnt_q;
    decay_pre_d = decay_pre_q;
    if (!enable) begin
      pwm_pre_d   = {PRE_W{1'b0}};
      pwm_cnt_d   = level_t'(0);
      decay_pre_d = {DEC_W{1'b0}};
    end else begin
      pwm_pre_d = pwm_tick ? {PRE_W{1'b0}} : (pwm_pre_q + PRE_W'(1));
      if (pwm_tick) begin
        pwm_cnt_d = (pwm_cnt_q == CNT_TOP) ? level_t'(0) : (pwm_cnt_q + level_t'(1));
      end else begin
        pwm_cnt_d = pwm_cnt_q;
      end
      if (period_end) begin
        decay_pre_d = (decay_pre_q == DEC_TOP) ? {DEC_W{1'b0}} : (decay_pre_q + DEC_W'(1));
      end else begin
        decay_pre_d = decay_pre_q;
      end
    end
    fading_d = enable && (|fade_vec);
  end

  // Pattern capture, timers and fading flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q       <= {WIDTH{1'b0}};
      pwm_pre_q   <= {PRE_W{1'b0}};
      pwm_cnt_q   <= level_t'(0);
      decay_pre_q <= {DEC_W{1'b0}};
      fading_q    <= 1'b0;
    end else begin
      pat_q       <= pattern_in;
      pwm_pre_q   <= pwm_pre_d;
      pwm_cnt_q   <= pwm_cnt_d;
      decay_pre_q <= decay_pre_d;
      fading_q    <= fading_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    audio_nios_led_channel u_ch (
      .clk_i        (clk),
      .reset_i      (reset),
      .enable_i     (enable),
      .freeze_i     (freeze),
      .decay_tick_i (decay_tick),
      .pat_bit_i    (pat_q[i]),
      .pwm_cnt_i    (pwm_cnt_q),
      .led_o        (led_out[i]),
      .fade_o       (fade_vec[i])
    );
  end

  assign fading = fading_q;

endmodule

// File: tb/tb_audio_nios_led_fader.sv
// Directed bench for audio_nios_led_fader with PWM_DIV=1, DECAY_DIV=2:
// one PWM period is 15 cycles and a decay step lands on every 30th edge.
module tb_audio_nios_led_fader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        freeze;
  logic [25:0] pattern_in;
  logic [25:0] led_out;
  logic        fading;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cnt;
  int bad;

  audio_nios_led_fader #(
    .WIDTH     (26),
    .PWM_DIV   (1),
    .DECAY_DIV (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .freeze     (freeze),
    .pattern_in (pattern_in),
    .led_out    (led_out),
    .fading     (fading)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  // Counts samples after edges start..start+14 where led_out equals on_val.
  task automatic duty(input int start, input logic [25:0] on_val, output int c);
    run_to(start - 1);
    c = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (led_out === on_val) c++;
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; freeze = 1'b0; pattern_in = 26'h0;
    repeat (3) step();
    cyc = 0;
    check_eq("rst_led", 32'(led_out), 32'h0);
    check_eq("rst_fading", 32'(fading), 32'h0);

    reset = 1'b0; enable = 1'b1; pattern_in = 26'h1;
    step();
    check_eq("lat_e1", 32'(led_out), 32'h0);
    step();
    check_eq("lat_e2", 32'(led_out), 32'h0);
    bad = 0;
    while (cyc < 40) begin
      step();
      if (led_out !== 26'h1 || fading !== 1'b0) bad++;
    end
    check_eq("hold_full", 32'(bad), 32'h0);

    pattern_in = 26'h0;
    run_to(50);
    check_eq("fading_at_full", 32'(fading), 32'h0);
    duty(61, 26'h1, cnt);  check_eq("duty14", 32'(cnt), 32'd14);
    run_to(80);
    check_eq("fading_on", 32'(fading), 32'h1);
    duty(91, 26'h1, cnt);  check_eq("duty13", 32'(cnt), 32'd13);

    freeze = 1'b1;
    duty(121, 26'h1, cnt); check_eq("frz_duty_a", 32'(cnt), 32'd13);
    run_to(150);
    check_eq("frz_fading", 32'(fading), 32'h1);
    duty(181, 26'h1, cnt); check_eq("frz_duty_b", 32'(cnt), 32'd13);
    run_to(205);
    freeze = 1'b0;
    duty(211, 26'h1, cnt); check_eq("unfrz_duty12", 32'(cnt), 32'd12);
    duty(361, 26'h1, cnt); check_eq("duty7", 32'(cnt), 32'd7);

    run_to(388);
    pattern_in = 26'h1;
    step();
    pattern_in = 26'h0;
    duty(391, 26'h1, cnt); check_eq("reassert_full", 32'(cnt), 32'd15);
    duty(421, 26'h1, cnt); check_eq("refade14", 32'(cnt), 32'd14);
    duty(811, 26'h1, cnt); check_eq("duty1", 32'(cnt), 32'd1);
    run_to(830);
    check_eq("fading_lvl1", 32'(fading), 32'h1);
    run_to(845);
    check_eq("faded_led", 32'(led_out), 32'h0);
    check_eq("faded_fading", 32'(fading), 32'h0);

    run_to(850);
    enable = 1'b0; pattern_in = 26'h3FFFFFF;
    run_to(852);
    check_eq("byp_lat", 32'(led_out), 32'h0);
    step();
    check_eq("byp_all", 32'(led_out), 32'h3FFFFFF);
    pattern_in = 26'h2AAAAAA;
    run_to(855);
    check_eq("byp_hold", 32'(led_out), 32'h3FFFFFF);
    check_eq("byp_fading", 32'(fading), 32'h0);
    step();
    check_eq("byp_alt", 32'(led_out), 32'h2AAAAAA);
    run_to(870);
    check_eq("byp_stable", 32'(led_out), 32'h2AAAAAA);

    enable = 1'b1; pattern_in = 26'h0;
    run_to(880);
    check_eq("reen_full", 32'(led_out), 32'h2AAAAAA);
    check_eq("reen_fading0", 32'(fading), 32'h0);
    duty(901, 26'h2AAAAAA, cnt); check_eq("reen_duty14", 32'(cnt), 32'd14);
    run_to(920);
    check_eq("reen_fading1", 32'(fading), 32'h1);

    run_to(925);
    pattern_in = 26'h1234567; reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("rst_mid_led", 32'(led_out), 32'h0);
    check_eq("rst_mid_fading", 32'(fading), 32'h0);
    run_to(929);
    check_eq("rst_recover", 32'(led_out), 32'h1234567);
    run_to(935);
    check_eq("rst_steady", 32'(led_out), 32'h1234567);
    check_eq("rst_steady_fading", 32'(fading), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
